// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the write-side FIFO arbiters.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STAT_WIDTH = 16;

    // Bits needed to hold an index 0..n-1; never returns less than 1 bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set request at or
// after ptr, scanning upward and wrapping modulo N. Shared by other arbiters.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk the N positions starting at ptr and latch the first request seen
    always_comb begin
        int   cand;
        logic found;
        cand  = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            for (int j = 0; j < N; j++) begin
                if (!found && (j == cand) && req[j]) begin
                    found = 1'b1;
                    idx   = IDX_W'(j);
                end
            end
        end
        any = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter sharing the dual-clock FIFO write port among NUM_REQ
// producers in the wr_clk domain. Round-robin grants, held for up to
// MAX_BURST words or until the owner marks req_last. Each grant change costs
// one IDLE cycle, so a word is never split across owners.
// Optional per-requester saturating transfer counters: FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int IDX_W      = idx_width(NUM_REQ),
    localparam int CNT_W      = idx_width(MAX_BURST)
) (
    input  logic                          wr_clk,
    input  logic                          wr_resetb,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_full,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_WIDTH-1:0] stat_count
`endif
);

    arb_state_t       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] burst_cnt;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             in_burst;
    logic             owner_valid;
    logic             owner_last;
    logic             xfer;
    logic             last_beat;
    logic [IDX_W-1:0] next_ptr;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign in_burst   = (state == BURST);
    assign xfer       = in_burst & owner_valid & ~fifo_full;
    assign last_beat  = owner_last | (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign next_ptr   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign fifo_wr_en = xfer;
    assign grant_id   = owner;
    assign busy       = in_burst;

    // Route the owner's handshake and word; fifo_full gates ready with no delay
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        fifo_din    = req_data[DATA_WIDTH-1:0];
        req_ready   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                owner_valid  = req_valid[i];
                owner_last   = req_last[i];
                fifo_din     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = in_burst & ~fifo_full;
            end
        end
    end

    // Arbitration FSM: pick in IDLE, forward words in BURST, release on
    // last / full burst / owner going quiet; a full FIFO simply freezes it
    always_ff @(posedge wr_clk or negedge wr_resetb) begin
        if (!wr_resetb) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner     <= pick_idx;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (!owner_valid) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end else if (!fifo_full) begin
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat_reg [NUM_REQ];

    // Count each requester's accepted words, sticking at all-ones
    always_ff @(posedge wr_clk or negedge wr_resetb) begin
        if (!wr_resetb) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer && (owner == IDX_W'(i)) && (stat_reg[i] != '1)) begin
                    stat_reg[i] <= stat_reg[i] + 1'b1;
                end
            end
        end
    end

    // Flatten the counters onto the packed status port
    always_comb begin
        stat_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_count[i*STAT_WIDTH +: STAT_WIDTH] = stat_reg[i];
        end
    end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter sharing the single write port of the dual-clock FIFO among `NUM_REQ` producers in the `wr_clk` domain. Grants are round-robin and held for a burst of up to `MAX_BURST` words, or until the owner signals `req_last`. Writes are forwarded straight to the FIFO write port and stalled by `fifo_full`. Grant changes never happen mid-word.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: word width; matches the FIFO `DATA_WIDTH`.
- `MAX_BURST`, 4: maximum words per grant, ≥1.
- `wr_clk`  in  1  write-domain clock.
- `wr_resetb`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester word valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  final word of the requester's packet.
- `req_ready`  out  NUM_REQ  word accepted when `req_valid[i] & req_ready[i]`.
- `fifo_wr_en`  out  1  to the FIFO `wr_en`.
- `fifo_din`  out  DATA_WIDTH  to the FIFO `din`.
- `fifo_full`  in  1  from the FIFO `full`.
- `grant_id`  out  $clog2(NUM_REQ)  current owner; holds its last value when idle.
- `busy`  out  1  high in the BURST state.
- `stat_count`  out  NUM_REQ*16  present only with `FIFO_WR_ARB_STATS_EN`.

## Operation
- States: IDLE and BURST.
- Registers: `owner`, `rr_ptr`, `burst_cnt` (counts 0..MAX_BURST-1).
- **IDLE:**
  - If `|req_valid`, pick the first valid index at or after `rr_ptr`, scanning upward modulo `NUM_REQ`.
  - Register the pick as `owner`, clear `burst_cnt`, go to BURST.
  - No transfer occurs in IDLE.
- **BURST:**
  - `req_ready[i] = (i == owner) & ~fifo_full`; all other bits are 0.
  - A transfer is `req_valid[owner] & req_ready[owner]`.
  - `fifo_wr_en` equals the transfer; `fifo_din = req_data[owner]` (combinational).
- **Exits from BURST to IDLE** (each sets `rr_ptr = owner + 1` mod `NUM_REQ`):
  - a transfer with `req_last[owner]` high;
  - a transfer when `burst_cnt == MAX_BURST-1`;
  - `req_valid[owner]` low in any cycle.
- A cycle where `fifo_full` is high and `req_valid[owner]` is high is a stall: stay in BURST, `burst_cnt` unchanged, no release.
- Each transfer that does not exit increments `burst_cnt`.
- Requesters must hold data stable while valid and not accepted.
- Reset, including mid-burst: state IDLE, `owner` 0, `rr_ptr` 0, `burst_cnt` 0, all `req_ready` 0, `fifo_wr_en` 0.
  - Any word not yet accepted is the producer's responsibility to resend.

## Timing
- Arbitration latency: 1 cycle. First `req_valid` at edge N gives BURST and `req_ready` at N+1.
- Back-to-back: after an exit at edge N, IDLE holds in cycle N+1 and the next owner's first word goes out at N+2. Every grant change costs one bubble cycle.
- `fifo_full` to `req_ready` is combinational (zero cycles). No write is ever issued while `fifo_full` is high.
- Sustained throughput: `MAX_BURST` words per `MAX_BURST+1` cycles with all requesters busy.
- Reset values: `req_ready` 0, `fifo_wr_en` 0, `fifo_din` = `req_data[0]`, `grant_id` 0, `busy` 0, `stat_count` 0.

## Configuration
- `FIFO_WR_ARB_STATS_EN` defined:
  - adds one 16-bit counter per requester, incremented on each of that requester's transfers;
  - counters saturate at 0xFFFF and are cleared only by reset;
  - the `stat_count` port exists.
- Not defined: no counters and no `stat_count` port. Arbitration behaviour is identical either way.

## Structure
- Package `fifo_arb_pkg`:
  - `arb_state_t` enum (IDLE, BURST);
  - `STAT_WIDTH = 16`;
  - a helper function for the width of `NUM_REQ` indices.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are the request vector and `rr_ptr`; outputs are the index and `any`. It is reused by other arbiters in the design.
- The top level holds the FSM, registers, output muxing and the optional counters.

## Test plan
- **Single requester:** req 2 sends 3 words 0x11, 0x22, 0x33 with last on 0x33 → `grant_id` = 2 one cycle after valid; `fifo_wr_en` high for 3 consecutive cycles; then IDLE.
- **All four continuously valid, no last, MAX_BURST=4** → grants in order 0, 1, 2, 3, 0; 4 words each; exactly one bubble between grants.
- **`fifo_full` high for 5 cycles mid-burst of req 1** → no `fifo_wr_en` during those cycles; `burst_cnt` frozen; req 1 keeps the grant and finishes its remaining words.
- **Owner req 3 drops valid after 2 words, req 0 valid** → release; `rr_ptr` = 0; req 0 granted after one IDLE cycle.
- **`wr_resetb` asserted mid-burst** → `req_ready`, `fifo_wr_en` and `busy` go to 0 immediately; after release, req 0 has priority.
- **With `FIFO_WR_ARB_STATS_EN`:** 70000 words from req 1 → its counter reads 0xFFFF; the other counters read 0.
